// File: rtl/router_rx_deser.sv
// Router ingress deserializer: decodes addr/pad/payload serial frames into a byte FIFO.
// Optional ROUTER_RX_STATS_EN adds saturating packet and drop counters.
module router_rx_deser #(
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned PAD_CYCLES = 5,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              din_i,
   input  logic              frame_n_i,
   input  logic              valid_n_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [7:0]        out_data_o,
   output logic [ADDR_W-1:0] out_dest_o,
   output logic              out_last_o,
   output logic              fifo_full_o,
   output logic              pkt_err_o,
   output logic [1:0]        err_code_o
`ifdef ROUTER_RX_STATS_EN
   ,
   output logic [15:0]       pkt_cnt_o,
   output logic [15:0]       drop_cnt_o
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = ADDR_W + 9;
   localparam int unsigned CW = $clog2(ADDR_W + PAD_CYCLES + 1);

   localparam logic [1:0] ErrTrunc = 2'd1;
   localparam logic [1:0] ErrOvfl  = 2'd2;
   localparam logic [1:0] ErrFrame = 2'd3;

   typedef enum logic [2:0] {StIdle, StAddr, StPad, StData, StDrop} state_e;

   state_e            state_q, state_d;
   logic              frame_prev_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [6:0]        byte_q, byte_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic [1:0]        code_q, code_d;

   logic              push;
   logic [EW-1:0]     push_entry;
   logic [EW-1:0]     mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_q, rd_q;
   logic [EW-1:0]     head;
   logic              empty, full, pop;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && out_ready_i;
   assign head  = mem_q[rd_q[AW-1:0]];

   // Address and payload bits arrive LSB first, so both registers shift right.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bitcnt_d   = bitcnt_q;
      byte_d     = byte_q;
      addr_d     = addr_q;
      err_d      = 1'b0;
      code_d     = code_q;
      push       = 1'b0;
      push_entry = {addr_q, frame_n_i, din_i, byte_q};

      unique case (state_q)
         StIdle: begin
            if (!frame_n_i && frame_prev_q) begin
               addr_d  = {din_i, addr_q[ADDR_W-1:1]};
               cnt_d   = CW'(1);
               state_d = StAddr;
            end
         end
         StAddr: begin
            if (frame_n_i || !valid_n_i) begin
               err_d   = 1'b1;
               code_d  = ErrFrame;
               state_d = StIdle;
            end else begin
               addr_d = {din_i, addr_q[ADDR_W-1:1]};
               if (cnt_q == CW'(ADDR_W - 1)) begin
                  cnt_d   = '0;
                  state_d = StPad;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StPad: begin
            if (frame_n_i || !valid_n_i) begin
               err_d   = 1'b1;
               code_d  = ErrFrame;
               state_d = StIdle;
            end else if (cnt_q == CW'(PAD_CYCLES - 1)) begin
               cnt_d    = '0;
               bitcnt_d = '0;
               state_d  = StData;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StData: begin
            if (!valid_n_i) begin
               if (bitcnt_q == 3'd7) begin
                  bitcnt_d = '0;
                  // A pop in the same cycle frees the slot, so full alone is not overflow.
                  if (full && !pop) begin
                     err_d   = 1'b1;
                     code_d  = ErrOvfl;
                     state_d = frame_n_i ? StIdle : StDrop;
                  end else begin
                     push = 1'b1;
                     if (frame_n_i) begin
                        state_d = StIdle;
                     end
                  end
               end else if (frame_n_i) begin
                  err_d   = 1'b1;
                  code_d  = ErrTrunc;
                  state_d = StIdle;
               end else begin
                  byte_d   = {din_i, byte_q[6:1]};
                  bitcnt_d = bitcnt_q + 3'd1;
               end
            end else if (frame_n_i) begin
               err_d   = 1'b1;
               code_d  = ErrTrunc;
               state_d = StIdle;
            end
         end
         StDrop: begin
            if (frame_n_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         frame_prev_q <= 1'b0;
         cnt_q        <= '0;
         bitcnt_q     <= '0;
         byte_q       <= '0;
         addr_q       <= '0;
         err_q        <= 1'b0;
         code_q       <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
      end else begin
         state_q      <= state_d;
         frame_prev_q <= frame_n_i;
         cnt_q        <= cnt_d;
         bitcnt_q     <= bitcnt_d;
         byte_q       <= byte_d;
         addr_q       <= addr_d;
         err_q        <= err_d;
         code_q       <= code_d;
         if (push) begin
            wr_q <= wr_q + PW'(1);
         end
         if (pop) begin
            rd_q <= rd_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (push) begin
         mem_q[wr_q[AW-1:0]] <= push_entry;
      end
   end

   // Storage is not reset, so the head is masked to keep outputs zero when empty.
   assign out_valid_o = !empty;
   assign out_data_o  = empty ? 8'h00 : head[7:0];
   assign out_last_o  = empty ? 1'b0 : head[8];
   assign out_dest_o  = empty ? '0 : head[EW-1:9];
   assign fifo_full_o = full;
   assign pkt_err_o   = err_q;
   assign err_code_o  = code_q;

`ifdef ROUTER_RX_STATS_EN
   logic [15:0] pkt_cnt_q, drop_cnt_q;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (push && frame_n_i && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
         end
         if (err_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign pkt_cnt_o  = pkt_cnt_q;
   assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_rx_deser.sv
// Randomized bench for router_rx_deser: packet-level model predicts FIFO entries and errors.
module tb_router_rx_deser;

   localparam int unsigned Depth = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       frame_n = 1'b1;
   logic       valid_n = 1'b1;
   logic       out_ready = 1'b0;
   logic       out_valid, out_last, fifo_full, pkt_err;
   logic [7:0] out_data;
   logic [3:0] out_dest;
   logic [1:0] err_code;
`ifdef ROUTER_RX_STATS_EN
   logic [15:0] pkt_cnt, drop_cnt;
`endif

   router_rx_deser #(
      .ADDR_W    (4),
      .PAD_CYCLES(5),
      .FIFO_DEPTH(Depth)
   ) dut (
      .clock_i    (clk),
      .reset_i    (rst),
      .din_i      (din),
      .frame_n_i  (frame_n),
      .valid_n_i  (valid_n),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .out_dest_o (out_dest),
      .out_last_o (out_last),
      .fifo_full_o(fifo_full),
      .pkt_err_o  (pkt_err),
      .err_code_o (err_code)
`ifdef ROUTER_RX_STATS_EN
      ,
      .pkt_cnt_o  (pkt_cnt),
      .drop_cnt_o (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int err_seen = 0;
   int pops = 0;
   int exp_errs = 0;
   logic [1:0] exp_code = 2'd0;
   bit rdy_en = 1'b1;
   bit rdy_rand = 1'b0;
   logic [12:0] exp_q[$];
   logic [7:0] pay[64];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = rdy_en && (!rdy_rand || ($urandom_range(0, 1) == 1));
      end
   end

   // Every accepted head entry is scored against the model queue.
   logic [12:0] mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (pkt_err) err_seen++;
         if (out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_pop", {19'd0, out_dest, out_last, out_data}, 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("pop_entry", {19'd0, out_dest, out_last, out_data}, {19'd0, mon_e});
            end
         end
      end
   end

   task automatic drive(input logic f, input logic v, input logic d);
      @(posedge clk);
      #1;
      frame_n = f;
      valid_n = v;
      din     = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0);
   endtask

   // Expected result of a packet from the protocol rules alone.
   task automatic model_pkt(input logic [3:0] dest, input int nbits, input int pad_err,
                            input bit ready_on);
      int  nfull;
      bit  trunc;
      if (pad_err >= 0) begin
         exp_errs++;
         exp_code = 2'd3;
         return;
      end
      nfull = nbits / 8;
      trunc = (nbits % 8) != 0;
      for (int b = 0; b < nfull; b++) begin
         if (!ready_on && b >= Depth) begin
            exp_errs++;
            exp_code = 2'd2;
            return;
         end
         exp_q.push_back({dest, (!trunc && b == nfull - 1), pay[b]});
      end
      if (trunc) begin
         exp_errs++;
         exp_code = 2'd1;
      end
   endtask

   task automatic send_pkt(input logic [3:0] dest, input int nbits, input int stall_pct,
                           input int stall_bit, input int pad_err);
      logic [7:0] b;
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, dest[i]);
      for (int k = 0; k < 5; k++) begin
         if (k == pad_err) begin
            idle(2);
            return;
         end
         drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      end
      for (int j = 0; j < nbits; j++) begin
         if (j == stall_bit) begin
            for (int s = 0; s < 3; s++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
         end
         if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
            drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
         end
         b = pay[j / 8];
         drive(j == nbits - 1, 1'b0, b[j % 8]);
      end
      idle(1);
   endtask

   task automatic finish_pkt(input string tag);
      for (int c = 0; c < 400 && (exp_q.size() != 0 || out_valid); c++) @(negedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_drained"}, exp_q.size(), 0);
      check_eq({tag, "_err_pulses"}, err_seen, exp_errs);
      check_eq({tag, "_err_code"}, {30'd0, err_code}, {30'd0, exp_code});
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_valid"}, {31'd0, out_valid}, 0);
      check_eq({tag, "_full"}, {31'd0, fifo_full}, 0);
      check_eq({tag, "_pkt_err"}, {31'd0, pkt_err}, 0);
      check_eq({tag, "_err_code"}, {30'd0, err_code}, 0);
      check_eq({tag, "_head"}, {19'd0, out_dest, out_last, out_data}, 0);
   endtask

   task automatic run_pkt(input string tag, input logic [3:0] dest, input int nbits,
                          input int stall_pct, input int stall_bit, input int pad_err);
      model_pkt(dest, nbits, pad_err, 1'b1);
      send_pkt(dest, nbits, stall_pct, stall_bit, pad_err);
      finish_pkt(tag);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int p0;
      logic [7:0] b;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      pay[0] = 8'hA5; pay[1] = 8'h3C;
      run_pkt("basic", 4'h5, 16, 0, -1, -1);
      run_pkt("stall", 4'h5, 16, 0, 4, -1);
      pay[0] = 8'h96; pay[1] = 8'h0F;
      run_pkt("trunc", 4'h9, 12, 0, -1, -1);
      run_pkt("pad_err", 4'h3, 16, 0, -1, 1);
      pay[0] = 8'h7E;
      run_pkt("after_pad_err", 4'hC, 8, 0, -1, -1);

      // Overflow: consumer stalled for a 17-byte packet.
      rdy_en = 1'b0;
      idle(3);
      for (int i = 0; i < 17; i++) pay[i] = 8'($urandom);
      model_pkt(4'h6, 136, -1, 1'b0);
      send_pkt(4'h6, 136, 0, -1, -1);
      @(negedge clk);
      check_eq("ovfl_full", {31'd0, fifo_full}, 1);
      check_eq("ovfl_valid", {31'd0, out_valid}, 1);
      p0 = pops;
      rdy_en = 1'b1;
      finish_pkt("ovfl");
      check_eq("ovfl_drain_count", pops - p0, Depth);

      // Reset mid-payload, then frame_n held low must be ignored.
      pay[0] = 8'h5A; pay[1] = 8'hC3;
      exp_q.push_back({4'h2, 1'b0, 8'h5A});
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'(i == 1));
      for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 12; j++) begin
         b = pay[j / 8];
         drive(1'b0, 1'b0, b[j % 8]);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("mid_reset");
      check_eq("mid_reset_sb", exp_q.size(), 0);
      exp_code = 2'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      idle(2);
      check_eq("ignored_frame", pops, pops);
      p0 = pops;
      pay[0] = 8'h01;
      run_pkt("post_reset", 4'hF, 8, 0, -1, -1);
      check_eq("post_reset_pops", pops - p0, 1);

      // Randomized packets with a jittery consumer.
      rdy_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         logic [3:0] dest;
         int nbits, pe;
         dest  = 4'($urandom);
         nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 79))
                                             : 8 * int'($urandom_range(1, 10));
         pe    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
         for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
         run_pkt("rand", dest, nbits, 25, -1, pe);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
